// File: rtl/gpio_cfg_loader.sv
// gpio_cfg_loader
// Turns the PS GPIO control bus into PL configuration traffic. Each serial
// clock line shifts the shared data bit (GPIO bit 0) into its own word. A
// completed word is queued as pending and then written through a single
// config write port. Line 2 is the exception: it loads channel_sel directly.
// Level lines are synchronised, and the trigger and flush lines become
// one-cycle pulses.

module gpio_cfg_loader #(
    parameter int GPIO_W      = 16,
    parameter int REG_W       = 32,
    parameter int SEL_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [SEL_W-1:0]  channel_sel,
    output logic              cfg_wr_en,
    output logic [3:0]        cfg_wr_addr,
    output logic [REG_W-1:0]  cfg_wr_data,
    output logic              cfg_overrun,
    output logic              pl_rst_req,
    output logic              trigger_pulse,
    output logic              adc_flush_pulse,
    output logic              adc_use_dummy_data,
    output logic              adc_readout_enable
);

    // Function codes are fixed at 16 regardless of bus width.
    localparam int FUNC_N = 16;
    localparam int CNT_W  = $clog2(REG_W);

    // Word width of each serial line; 0 marks a non-serial line.
    function automatic int line_width(input int k);
        case (k)
            1, 3, 7, 8, 9, 10, 11: line_width = REG_W;
            2:                     line_width = SEL_W;
            4, 12:                 line_width = 1;
            default:               line_width = 0;
        endcase
    endfunction

    // Mask with the low w bits set, so narrow words come out zero-extended.
    function automatic logic [REG_W-1:0] width_mask(input int w);
        logic [REG_W-1:0] m;
        m = '0;
        for (int i = 0; i < REG_W; i++) begin
            if (i < w) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [GPIO_W-1:0] sync_r [SYNC_STAGES];
    logic [GPIO_W-1:0] hist_r;
    logic [GPIO_W-1:0] gpio_s;
    logic [GPIO_W-1:0] rise_s;
    logic              sdata_s;
    logic              abort_s;

    logic [REG_W-2:0]  shift_r     [FUNC_N];
    logic [REG_W-1:0]  hold_r      [FUNC_N];
    logic [CNT_W-1:0]  cnt_r       [FUNC_N];
    logic [REG_W-1:0]  next_word_s [FUNC_N];
    logic [FUNC_N-1:0] pending_r;
    logic              sel_load_r;
    logic [SEL_W-1:0]  channel_sel_r;
    logic              overrun_r;

    logic              grant_valid_s;
    logic [3:0]        grant_idx_s;

    // Synchroniser chain plus one history stage used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
            hist_r <= '0;
        end else begin
            sync_r[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Data and clock lines come from the same synchronised vector, so they share latency.
    always_comb begin
        gpio_s  = sync_r[SYNC_STAGES-1];
        rise_s  = gpio_s & ~hist_r;
        sdata_s = gpio_s[0];
        abort_s = gpio_s[5];
    end

    // Candidate word per line: shift in the data bit and trim to the line's width.
    always_comb begin
        for (int k = 0; k < FUNC_N; k++) begin
            next_word_s[k] = {shift_r[k], sdata_s} & width_mask(line_width(k));
        end
    end

    // Fixed-priority arbiter: the lowest pending function code wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 4'd0;
        for (int k = FUNC_N - 1; k >= 0; k--) begin
            if (pending_r[k]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 4'(k);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Per-line shift, bit count, completion, pending flags and channel_sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FUNC_N; k++) begin
                shift_r[k] <= '0;
                hold_r[k]  <= '0;
                cnt_r[k]   <= '0;
            end
            pending_r     <= '0;
            sel_load_r    <= 1'b0;
            channel_sel_r <= '0;
            overrun_r     <= 1'b0;
        end else begin
            sel_load_r <= 1'b0;
            for (int k = 0; k < FUNC_N; k++) begin
                if (line_width(k) == 0) begin
                    // Not a serial line: no per-line state.
                end else if (abort_s) begin
                    cnt_r[k]     <= '0;
                    pending_r[k] <= 1'b0;
                end else begin
                    // A grant clears pending. A completion in the same cycle overrides it below.
                    if (grant_valid_s && (grant_idx_s == 4'(k))) begin
                        pending_r[k] <= 1'b0;
                    end
                    if (rise_s[k]) begin
                        shift_r[k] <= next_word_s[k][REG_W-2:0];
                        if (cnt_r[k] == CNT_W'(line_width(k) - 1)) begin
                            cnt_r[k]  <= '0;
                            hold_r[k] <= next_word_s[k];
                            if (k == 2) begin
                                sel_load_r <= 1'b1;
                            end else begin
                                pending_r[k] <= 1'b1;
                                if (pending_r[k]) begin
                                    overrun_r <= 1'b1;
                                end
                            end
                        end else begin
                            cnt_r[k] <= cnt_r[k] + CNT_W'(1);
                        end
                    end
                end
            end
            if (abort_s) begin
                channel_sel_r <= '0;
            end else if (sel_load_r) begin
                channel_sel_r <= hold_r[2][SEL_W-1:0];
            end
        end
    end

    // Registered write port, level outputs and edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_wr_en          <= 1'b0;
            cfg_wr_addr        <= 4'd0;
            cfg_wr_data        <= '0;
            pl_rst_req         <= 1'b0;
            trigger_pulse      <= 1'b0;
            adc_flush_pulse    <= 1'b0;
            adc_use_dummy_data <= 1'b0;
            adc_readout_enable <= 1'b0;
        end else begin
            cfg_wr_en <= grant_valid_s & ~abort_s;
            if (grant_valid_s && !abort_s) begin
                cfg_wr_addr <= grant_idx_s;
                cfg_wr_data <= hold_r[grant_idx_s];
            end
            pl_rst_req         <= gpio_s[5];
            trigger_pulse      <= rise_s[6];
            adc_flush_pulse    <= rise_s[13];
            adc_use_dummy_data <= gpio_s[14];
            adc_readout_enable <= gpio_s[15];
        end
    end

    assign channel_sel = channel_sel_r;
    assign cfg_overrun = overrun_r;

endmodule
